cv32e40p_instr_obi_responder: RTL and testbench

- OBI instruction-side responder (slave) that serves the IF-stage fetch initiator.
- Backed by a word-addressed instruction memory array with a side-load port for boot and preload.
- Issues in-order responses with configurable grant throttling, minimum response latency, response stalls and range-error signalling.
- Used as the instruction memory model in core-level simulation, and as the insertion point for encrypted-image fetch tests.

---
 rtl/cv32e40p_instr_obi_responder.sv | 190 +++++++++++++++++++
 tb/tb_cv32e40p_instr_obi_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_obi_responder.sv
// OBI instruction-side responder backed by a word-addressed memory.
// Grants are combinational and gated on queue occupancy. Each granted
// access reads memory in the grant cycle and queues {data, err} with a
// latency countdown. Responses leave the queue strictly in grant order,
// at most one per cycle, through a registered rvalid/rdata/err stage.
// The entry pushed in the grant cycle is visible as head when the queue
// is empty, so RVALID_LATENCY=1 yields rvalid in the cycle after grant.
module cv32e40p_instr_obi_responder #(
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RVALID_LATENCY  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_req_i,
  input  logic [31:0]                            instr_addr_i,
  output logic                                   instr_gnt_o,
  output logic                                   instr_rvalid_o,
  output logic [31:0]                            instr_rdata_o,
  output logic                                   instr_err_o,
  input  logic                                   gnt_stall_i,
  input  logic                                   rvalid_stall_i,
  input  logic                                   load_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]           load_addr_i,
  input  logic [31:0]                            load_wdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   busy_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LW = (RVALID_LATENCY > 1) ? $clog2(RVALID_LATENCY) : 1;
  localparam logic [31:0]   MEM_BYTES = 32'(4 * MEM_DEPTH);
  localparam logic [LW-1:0] LAT_INIT  = LW'(RVALID_LATENCY - 1);
  localparam logic [CW-1:0] Q_FULL    = CW'(MAX_OUTSTANDING);

  // Reject parameter values the queue and decode logic are not built for.
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be in 1..4");
  end
  if (RVALID_LATENCY < 1 || RVALID_LATENCY > 8) begin : g_bad_latency
    $error("RVALID_LATENCY must be in 1..8");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDR must be word-aligned");
  end

  // One queued response: payload plus remaining cycles until it may pop.
  typedef struct packed {
    logic [31:0]   data;
    logic          err;
    logic [LW-1:0] cnt;
  } entry_t;

  // Countdowns saturate at zero; a stalled head simply waits at zero.
  function automatic logic [LW-1:0] dec_cnt(input logic [LW-1:0] c);
    return (c != '0) ? c - LW'(1) : c;
  endfunction

  function automatic entry_t age_entry(input entry_t e);
    entry_t r;
    r     = e;
    r.cnt = dec_cnt(e.cnt);
    return r;
  endfunction

  logic [31:0] mem [MEM_DEPTH];

  entry_t        q_q [MAX_OUTSTANDING];
  entry_t        q_d [MAX_OUTSTANDING];
  logic [CW-1:0] count_q, count_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic          gnt;
  logic          push;
  logic          pop;
  logic          head_valid;
  entry_t        in_entry;
  entry_t        head;

  // Address decode; the subtraction wraps, so addresses below BASE_ADDR
  // land far above the array and decode as out of range.
  assign off       = instr_addr_i - BASE_ADDR;
  assign in_range  = (off < MEM_BYTES);
  assign word_idx  = off[AW+1:2];
  assign mem_rdata = mem[word_idx];

  // A full queue blocks grant even when the head pops this cycle.
  assign gnt  = instr_req_i & ~gnt_stall_i & (count_q < Q_FULL);
  assign push = instr_req_i & gnt;

  // Build the entry for this cycle's grant and select the response head.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    in_entry      = '0;
    in_entry.data = in_range ? mem_rdata : 32'h0;
    in_entry.err  = ~in_range;
    in_entry.cnt  = LAT_INIT;
    head          = in_entry;
    head_valid    = push;
    if (count_q != '0) begin
      head       = q_q[0];
      head_valid = 1'b1;
    end
    pop = head_valid & (head.cnt == '0) & ~rvalid_stall_i;
  end

  // Queue next state: age all entries, shift on pop, append on push.
  always_comb begin
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      q_d[i] = age_entry(q_q[i]);
    end
    count_d = count_q;
    if (pop && (count_q != '0)) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
        q_d[i] = age_entry(q_q[i+1]);
      end
      count_d = count_q - CW'(1);
    end
    // A grant into an empty queue that pops at once never occupies a slot.
    if (push && !(pop && (count_q == '0))) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (CW'(i) == count_d) begin
          q_d[i] = age_entry(in_entry);
        end
      end
      count_d = count_d + CW'(1);
    end
  end

  // Response stage next state: rdata/err hold when nothing pops.
  always_comb begin
    rvalid_d = pop;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (pop) begin
      rdata_d = head.data;
      err_d   = head.err;
    end
  end

  // Control state and response registers; reset discards pending responses.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Queue payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload and memory arrays carry no reset; slots are only read
    // when count_q marks them valid, and resetting arrays costs a mux per bit.
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      q_q[i] <= q_d[i];
    end
  end

  // Preload port; a same-cycle grant reads the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign outstanding_o  = count_q;
  assign busy_o         = (count_q != '0);

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// Bench for cv32e40p_instr_obi_responder: two instances (latency 1 and 3)
// share one stimulus stream. A transaction-level model (pending responses
// tagged with absolute due cycles) is compared against both every cycle,
// and directed sequences pin the model with hand-computed values.
module tb_cv32e40p_instr_obi_responder;

  localparam int DEPTH = 1024;
  localparam int MAXO  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        gstall;
  logic        rstall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic [1:0]  outst  [2];
  logic        busy   [2];

  int checks   = 0;
  int failures = 0;

  cv32e40p_instr_obi_responder #(
    .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO), .RVALID_LATENCY(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[0]),
    .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .gnt_stall_i(gstall), .rvalid_stall_i(rstall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outst[0]), .busy_o(busy[0])
  );

  cv32e40p_instr_obi_responder #(
    .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO), .RVALID_LATENCY(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[1]),
    .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .gnt_stall_i(gstall), .rvalid_stall_i(rstall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outst[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int          k;
    logic [31:0] data;
    logic        err;
    longint      due;
  } pend_t;

  pend_t       mq [$];
  logic [31:0] mem_m [DEPTH];
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  longint      cyc = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Compare and advance the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
        check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
        check($sformatf("rst_outst%0d", k), 32'(outst[k]), 32'd0);
        check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
        exp_rv[k] = 1'b0;
        exp_rd[k] = 32'h0;
        exp_er[k] = 1'b0;
      end
      mq.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int          n;
        int          hi;
        logic        e_gnt;
        logic [31:0] off;
        pend_t       p;
        n = 0;
        foreach (mq[i]) if (mq[i].k == k) n++;
        e_gnt = req && !gstall && (n < MAXO);
        check($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(e_gnt));
        check($sformatf("outst%0d", k), 32'(outst[k]), 32'(n));
        check($sformatf("busy%0d", k), 32'(busy[k]), 32'(n != 0));
        check($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(exp_rv[k]));
        check($sformatf("rdata%0d", k), rdata[k], exp_rd[k]);
        check($sformatf("err%0d", k), 32'(err[k]), 32'(exp_er[k]));
        if (e_gnt) begin
          off    = addr - BASE;
          p.k    = k;
          p.due  = cyc + longint'(lat_of(k) - 1);
          if (off < 32'(4 * DEPTH)) begin
            p.data = mem_m[off[11:2]];
            p.err  = 1'b0;
          end else begin
            p.data = 32'h0;
            p.err  = 1'b1;
          end
          mq.push_back(p);
        end
        hi = -1;
        foreach (mq[i]) if (mq[i].k == k && hi < 0) hi = i;
        exp_rv[k] = 1'b0;
        if (hi >= 0 && mq[hi].due <= cyc && !rstall) begin
          exp_rv[k] = 1'b1;
          exp_rd[k] = mq[hi].data;
          exp_er[k] = mq[hi].err;
          mq.delete(hi);
        end
      end
      if (load_we) mem_m[load_addr] = load_wdata;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pv [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; gstall = 1'b0; rstall = 1'b0; load_we = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rv_seen;
    logic [31:0] newv;
    rst_n = 1'b1; req = 1'b0; addr = 32'h0; gstall = 1'b0; rstall = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload the whole array; word 0 holds a NOP encoding.
    for (int i = 0; i < DEPTH; i++) begin
      load_we    = 1'b1;
      load_addr  = 10'(i);
      load_wdata = (i == 0) ? 32'h0000_0013 : $urandom;
      pv[i]      = load_wdata;
      tick();
    end
    idle(3);

    // Single fetch, latency 1.
    req = 1'b1; addr = 32'h0;
    @(negedge clk); check("t1_gnt", 32'(gnt[0]), 32'd1);
    tick(); req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", 32'(rvalid[0]), 32'd1);
    check("t1_rdata", rdata[0], 32'h0000_0013);
    check("t1_err", 32'(err[0]), 32'd0);
    tick();
    @(negedge clk); check("t1_outst", 32'(outst[0]), 32'd0);
    idle(6);

    // Queue-full blocking with latency 3.
    req = 1'b1; addr = 32'h0;
    @(negedge clk); check("t2_gnt_a", 32'(gnt[1]), 32'd1);
    tick(); addr = 32'h4;
    @(negedge clk); check("t2_gnt_b", 32'(gnt[1]), 32'd1);
    tick(); addr = 32'h8;
    @(negedge clk); check("t2_gnt_full", 32'(gnt[1]), 32'd0);
    tick();
    @(negedge clk);
    check("t2_gnt_c", 32'(gnt[1]), 32'd1);
    check("t2_rv_a", 32'(rvalid[1]), 32'd1);
    check("t2_rd_a", rdata[1], pv[0]);
    tick(); req = 1'b0;
    @(negedge clk);
    check("t2_rv_b", 32'(rvalid[1]), 32'd1);
    check("t2_rd_b", rdata[1], pv[1]);
    tick();
    @(negedge clk); check("t2_rv_gap", 32'(rvalid[1]), 32'd0);
    tick();
    @(negedge clk);
    check("t2_rv_c", 32'(rvalid[1]), 32'd1);
    check("t2_rd_c", rdata[1], pv[2]);
    idle(6);

    // Range errors: one past the end, and wrap below the base.
    req = 1'b1; addr = BASE + 32'(4 * DEPTH);
    @(negedge clk); check("t3_gnt_hi", 32'(gnt[0]), 32'd1);
    tick(); addr = BASE - 32'd4;
    @(negedge clk);
    check("t3_gnt_lo", 32'(gnt[0]), 32'd1);
    check("t3_err_hi", 32'(err[0]), 32'd1);
    check("t3_rd_hi", rdata[0], 32'h0);
    tick(); req = 1'b0;
    @(negedge clk);
    check("t3_rv_lo", 32'(rvalid[0]), 32'd1);
    check("t3_err_lo", 32'(err[0]), 32'd1);
    check("t3_rd_lo", rdata[0], 32'h0);
    idle(6);

    // Grant stall with a wandering address.
    req = 1'b1; gstall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = $urandom;
      @(negedge clk);
      check("t4_gnt0_stall", 32'(gnt[0]), 32'd0);
      check("t4_gnt1_stall", 32'(gnt[1]), 32'd0);
      check("t4_outst1_stall", 32'(outst[1]), 32'd0);
      tick();
    end
    gstall = 1'b0; addr = 32'hC;
    @(negedge clk); check("t4_gnt_rel", 32'(gnt[0]), 32'd1);
    tick(); req = 1'b0; addr = $urandom;
    @(negedge clk);
    check("t4_rv", 32'(rvalid[0]), 32'd1);
    check("t4_rd", rdata[0], pv[3]);
    idle(6);

    // Response stall over two due responses, latency 3.
    req = 1'b1; addr = 32'h10;
    @(negedge clk);
    tick(); addr = 32'h14;
    @(negedge clk);
    tick(); req = 1'b0; rstall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t5_rv_stalled", 32'(rvalid[1]), 32'd0);
      tick();
    end
    rstall = 1'b0;
    @(negedge clk); check("t5_rv_rel", 32'(rvalid[1]), 32'd0);
    tick();
    @(negedge clk);
    check("t5_rv_a", 32'(rvalid[1]), 32'd1);
    check("t5_rd_a", rdata[1], pv[4]);
    tick();
    @(negedge clk);
    check("t5_rv_b", 32'(rvalid[1]), 32'd1);
    check("t5_rd_b", rdata[1], pv[5]);
    idle(6);

    // Reset with two responses outstanding.
    req = 1'b1; addr = 32'h0;
    tick(); addr = 32'h4;
    tick(); req = 1'b0;
    check("t6_outst_pre", 32'(outst[1]), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rv0_rst", 32'(rvalid[0]), 32'd0);
    check("t6_rv1_rst", 32'(rvalid[1]), 32'd0);
    check("t6_outst1_rst", 32'(outst[1]), 32'd0);
    tick(); rst_n = 1'b1;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid[0] || rvalid[1]) rv_seen++;
      tick();
    end
    check("t6_no_rv_after_rst", 32'(rv_seen), 32'd0);

    // Same-cycle load and grant of word 5 reads the old value.
    newv = ~pv[5];
    req = 1'b1; addr = 32'h14; load_we = 1'b1; load_addr = 10'd5; load_wdata = newv;
    @(negedge clk);
    tick(); req = 1'b0; load_we = 1'b0;
    @(negedge clk);
    check("t7_rv_old", 32'(rvalid[0]), 32'd1);
    check("t7_rd_old", rdata[0], pv[5]);
    pv[5] = newv;
    tick(); req = 1'b1; addr = 32'h14;
    @(negedge clk);
    tick(); req = 1'b0;
    @(negedge clk); check("t7_rd_new", rdata[0], newv);
    idle(6);

    // Randomised traffic with occasional long response stalls and a reset.
    for (int c = 0; c < 3000; c++) begin
      int r;
      req = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
      else             addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(0, 3));
      gstall = ($urandom_range(0, 9) == 0);
      rstall = ((c % 200) < 15) ? 1'b1 : ($urandom_range(0, 4) == 0);
      load_we    = ($urandom_range(0, 7) == 0);
      load_addr  = 10'($urandom_range(0, DEPTH - 1));
      load_wdata = $urandom;
      rst_n = (c != 1500);
      tick();
    end
    rst_n = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
